// File: rtl/jtpopeye_inputs_pkg.sv
// Shared constants for the Popeye cabinet input conditioner: PS/2 scan codes,
// HPS joystick bit positions, the decoded key record and the coin FSM states.
package jtpopeye_inputs_pkg;

  // {extended, code}
  localparam logic [8:0] SC_UP    = 9'h175;
  localparam logic [8:0] SC_DOWN  = 9'h172;
  localparam logic [8:0] SC_LEFT  = 9'h16B;
  localparam logic [8:0] SC_RIGHT = 9'h174;
  localparam logic [8:0] SC_LCTRL = 9'h014;
  localparam logic [8:0] SC_RCTRL = 9'h114;
  localparam logic [8:0] SC_F1    = 9'h005;
  localparam logic [8:0] SC_F2    = 9'h006;
  localparam logic [8:0] SC_F3    = 9'h004;
  localparam logic [8:0] SC_F4    = 9'h00C;

  localparam int JB_RIGHT  = 0;
  localparam int JB_LEFT   = 1;
  localparam int JB_DOWN   = 2;
  localparam int JB_UP     = 3;
  localparam int JB_PUNCH  = 4;
  localparam int JB_START1 = 6;
  localparam int JB_START2 = 7;
  localparam int JB_COIN   = 8;
  localparam int JB_PAUSE  = 9;

  typedef struct packed {
    logic punch;
    logic up;
    logic down;
    logic left;
    logic right;
    logic start1;
    logic start2;
    logic coin;
    logic pause;
  } keys_t;

  typedef enum logic [1:0] {IDLE, PULSE, HOLD} coin_st_t;

endpackage

// File: rtl/jtpopeye_coin_oneshot.sv
// Turns a held coin request into one active-low pulse of exactly COIN_LEN cycles.
// Output lags trig by two cycles; a new pulse needs trig to drop first.
module jtpopeye_coin_oneshot
  import jtpopeye_inputs_pkg::*;
#(
  parameter int COINW    = 20,
  parameter int COIN_LEN = 400000
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic trig,
  output logic pulse_n
);

  localparam logic [COINW-1:0] CNT_LOAD = COINW'(COIN_LEN - 1);

  coin_st_t         st_q, st_d;
  logic [COINW-1:0] cnt_q, cnt_d;
  logic             pulse_n_q, pulse_n_d;

  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    pulse_n_d = (st_q != PULSE);
    if (flush) begin
      st_d      = IDLE;
      cnt_d     = '0;
      pulse_n_d = 1'b1;
    end else begin
      case (st_q)
        IDLE:    if (trig) begin
                   st_d  = PULSE;
                   cnt_d = CNT_LOAD;
                 end
        // trig is ignored here so a short tap still yields a full-length coin
        PULSE:   if (cnt_q == '0) st_d = HOLD;
                 else cnt_d = cnt_q - COINW'(1);
        HOLD:    if (!trig) st_d = IDLE;
        default: st_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= IDLE;
      cnt_q     <= '0;
      pulse_n_q <= 1'b1;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      pulse_n_q <= pulse_n_d;
    end
  end

  assign pulse_n = pulse_n_q;

endmodule

// File: rtl/jtpopeye_inputs.sv
// Merges PS/2 key events and HPS joysticks into Popeye's active-low controls,
// with a coin one-shot and a toggling pause; every output is registered.
module jtpopeye_inputs
  import jtpopeye_inputs_pkg::*;
#(
  parameter int COINW    = 20,
  parameter int COIN_LEN = 400000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy_0,
  input  logic [15:0] joy_1,
  input  logic        flush,
  input  logic        pause_clr,
  output logic [4:0]  joystick1,
  output logic [4:0]  joystick2,
  output logic [1:0]  start_button,
  output logic        coin_input,
  output logic        dip_pause
);

  logic       tog_q, tog_d, armed_q, armed_d, evt;
  keys_t      key_q, key_d;
  logic       pause_q, pause_d, pause_prev_q, pause_prev_d;
  logic [4:0] joystick1_q, joystick1_d, joystick2_q, joystick2_d;
  logic [1:0] start_button_q, start_button_d;
  logic       dip_pause_q, dip_pause_d;
  logic [4:0] raw_j1;
  logic [1:0] raw_start;
  logic       raw_coin, raw_pause;
  logic       unused_bits;

  assign unused_bits = ^{joy_0[15:10], joy_0[5], joy_1[15:5]};

  // armed keeps the toggle level seen at reset from counting as a key event
  assign evt = armed_q & (ps2_key[10] != tog_q);

  always_comb begin
    tog_d   = ps2_key[10];
    armed_d = 1'b1;
    key_d   = key_q;
    if (flush) begin
      key_d = '0;
    end else if (evt) begin
      case (ps2_key[8:0])
        SC_UP:              key_d.up     = ps2_key[9];
        SC_DOWN:            key_d.down   = ps2_key[9];
        SC_LEFT:            key_d.left   = ps2_key[9];
        SC_RIGHT:           key_d.right  = ps2_key[9];
        SC_LCTRL, SC_RCTRL: key_d.punch  = ps2_key[9];
        SC_F1:              key_d.start1 = ps2_key[9];
        SC_F2:              key_d.start2 = ps2_key[9];
        SC_F3:              key_d.coin   = ps2_key[9];
        SC_F4:              key_d.pause  = ps2_key[9];
        default: ;
      endcase
    end
  end

  always_comb begin
    raw_j1    = {key_q.punch | joy_0[JB_PUNCH], key_q.up   | joy_0[JB_UP],
                 key_q.down  | joy_0[JB_DOWN],  key_q.left | joy_0[JB_LEFT],
                 key_q.right | joy_0[JB_RIGHT]};
    raw_start = {key_q.start2 | joy_0[JB_START2], key_q.start1 | joy_0[JB_START1]};
    raw_coin  = key_q.coin  | joy_0[JB_COIN];
    raw_pause = key_q.pause | joy_0[JB_PAUSE];

    pause_prev_d = raw_pause;
    pause_d      = pause_q;
    if (pause_clr) pause_d = 1'b0;
    else if (!flush && raw_pause && !pause_prev_q) pause_d = ~pause_q;

    joystick1_d    = flush ? 5'h1F : ~raw_j1;
    joystick2_d    = flush ? 5'h1F : ~joy_1[4:0];
    start_button_d = flush ? 2'b11 : ~raw_start;
    dip_pause_d    = ~pause_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tog_q          <= 1'b0;
      armed_q        <= 1'b0;
      key_q          <= '0;
      pause_q        <= 1'b0;
      pause_prev_q   <= 1'b0;
      joystick1_q    <= 5'h1F;
      joystick2_q    <= 5'h1F;
      start_button_q <= 2'b11;
      dip_pause_q    <= 1'b1;
    end else begin
      tog_q          <= tog_d;
      armed_q        <= armed_d;
      key_q          <= key_d;
      pause_q        <= pause_d;
      pause_prev_q   <= pause_prev_d;
      joystick1_q    <= joystick1_d;
      joystick2_q    <= joystick2_d;
      start_button_q <= start_button_d;
      dip_pause_q    <= dip_pause_d;
    end
  end

  jtpopeye_coin_oneshot #(
    .COINW    (COINW),
    .COIN_LEN (COIN_LEN)
  ) u_coin (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .trig    (raw_coin),
    .pulse_n (coin_input)
  );

  assign joystick1    = joystick1_q;
  assign joystick2    = joystick2_q;
  assign start_button = start_button_q;
  assign dip_pause    = dip_pause_q;

endmodule

// File: tb/tb_jtpopeye_inputs.sv
// Directed bench: a 4-cycle-coin instance plus an 8-cycle-coin instance on shared inputs,
// with expected outputs queued at stimulus time and checked when their cycle arrives.
module tb_jtpopeye_inputs;

  localparam int S_J1 = 0, S_J2 = 1, S_ST = 2, S_COIN = 3, S_PAUSE = 4, S_COIN8 = 5, S_ALL = 6;
  localparam logic [14:0] IDLE_ALL = {5'h1F, 5'h1F, 2'b11, 1'b1, 1'b1, 1'b1};

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] ps2_key;
  logic [15:0] joy_0, joy_1;
  logic        flush, pause_clr;
  logic [4:0]  joystick1, joystick2, j1_8, j2_8;
  logic [1:0]  start_button, st_8;
  logic        coin_input, dip_pause, coin_8, pause_8;

  always #5 clk = ~clk;

  jtpopeye_inputs #(.COINW(20), .COIN_LEN(4)) dut (
    .clk(clk), .rst(rst), .ps2_key(ps2_key), .joy_0(joy_0), .joy_1(joy_1),
    .flush(flush), .pause_clr(pause_clr), .joystick1(joystick1), .joystick2(joystick2),
    .start_button(start_button), .coin_input(coin_input), .dip_pause(dip_pause)
  );

  jtpopeye_inputs #(.COINW(20), .COIN_LEN(8)) dut8 (
    .clk(clk), .rst(rst), .ps2_key(ps2_key), .joy_0(joy_0), .joy_1(joy_1),
    .flush(flush), .pause_clr(pause_clr), .joystick1(j1_8), .joystick2(j2_8),
    .start_button(st_8), .coin_input(coin_8), .dip_pause(pause_8)
  );

  typedef struct {
    int          due;
    string       tag;
    int          sel;
    logic [14:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic tog = 1'b1;

  function automatic logic [14:0] observe(int sel);
    case (sel)
      S_J1:    return 15'(joystick1);
      S_J2:    return 15'(joystick2);
      S_ST:    return 15'(start_button);
      S_COIN:  return 15'(coin_input);
      S_PAUSE: return 15'(dip_pause);
      S_COIN8: return 15'(coin_8);
      default: return {joystick1, joystick2, start_button, coin_input, dip_pause, coin_8};
    endcase
  endfunction

  task automatic compare(input string tag, input int sel, input logic [14:0] exp);
    logic [14:0] got;
    got = observe(sel);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s @cycle %0d: observed %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic expect_at(input int ofs, input string tag, input int sel, input logic [14:0] v);
    sb.push_back('{cyc + ofs, tag, sel, v});
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        compare(sb[i].tag, sb[i].sel, sb[i].val);
        sb.delete(i);
      end
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic send_key(input logic pr, input logic ext, input logic [7:0] code);
    tog = ~tog;
    ps2_key = {tog, pr, ext, code};
  endtask

  initial begin
    rst = 1'b1;
    ps2_key = {1'b1, 1'b1, 1'b1, 8'h75};  // toggle high and "up pressed" present at reset
    joy_0 = '0; joy_1 = '0; flush = 1'b0; pause_clr = 1'b0;
    ticks(3);
    compare("reset_values", S_ALL, IDLE_ALL);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) expect_at(k, "no_spurious_key", S_J1, 15'(5'h1F));
    ticks(4);

    // arrow key with E0: press then release
    send_key(1'b1, 1'b1, 8'h75);
    expect_at(1, "kbd_up_lat1", S_J1, 15'(5'h1F));
    expect_at(2, "kbd_up_press", S_J1, 15'(5'b10111));
    ticks(3);
    send_key(1'b0, 1'b1, 8'h75);
    expect_at(1, "kbd_up_hold", S_J1, 15'(5'b10111));
    expect_at(2, "kbd_up_release", S_J1, 15'(5'h1F));
    ticks(3);

    // keypad 8 (no E0) must be ignored
    send_key(1'b1, 1'b0, 8'h75);
    for (int k = 1; k <= 3; k++) expect_at(k, "keypad_ignored", S_J1, 15'(5'h1F));
    ticks(3);
    send_key(1'b0, 1'b0, 8'h75);
    ticks(2);

    // right Ctrl punch and F1 start1
    send_key(1'b1, 1'b1, 8'h14);
    expect_at(2, "kbd_punch", S_J1, 15'(5'b01111));
    ticks(3);
    send_key(1'b0, 1'b1, 8'h14);
    expect_at(2, "kbd_punch_rel", S_J1, 15'(5'h1F));
    ticks(3);
    send_key(1'b1, 1'b0, 8'h05);
    expect_at(2, "kbd_start1", S_ST, 15'(2'b10));
    ticks(3);
    send_key(1'b0, 1'b0, 8'h05);
    expect_at(2, "kbd_start1_rel", S_ST, 15'(2'b11));
    ticks(3);

    // joysticks: one-cycle latency, players independent
    joy_1 = 16'hFFE5;
    joy_0[1] = 1'b1;
    expect_at(1, "joy2_bits", S_J2, 15'(5'b11010));
    expect_at(1, "joy1_left", S_J1, 15'(5'b11101));
    tick();
    joy_1 = '0; joy_0 = '0;
    expect_at(1, "joy_clear", S_ALL, IDLE_ALL);
    ticks(2);

    // coin held 20 cycles: one 4-cycle (and one 8-cycle) pulse
    joy_0[8] = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      expect_at(k, "coin4_held", S_COIN, 15'((k >= 2 && k <= 5) ? 0 : 1));
      expect_at(k, "coin8_held", S_COIN8, 15'((k >= 2 && k <= 9) ? 0 : 1));
    end
    ticks(20);
    joy_0[8] = 1'b0;
    ticks(2);

    // single-cycle tap: full-length pulse on both instances
    joy_0[8] = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      expect_at(k, "coin4_tap", S_COIN, 15'((k >= 2 && k <= 5) ? 0 : 1));
      expect_at(k, "coin8_tap", S_COIN8, 15'((k >= 2 && k <= 9) ? 0 : 1));
    end
    tick();
    joy_0[8] = 1'b0;
    ticks(10);

    // F4 pairs toggle pause
    send_key(1'b1, 1'b0, 8'h0C);
    expect_at(2, "f4_a_lat", S_PAUSE, 15'(1));
    expect_at(3, "f4_a_paused", S_PAUSE, 15'(0));
    ticks(3);
    send_key(1'b0, 1'b0, 8'h0C);
    expect_at(3, "f4_a_rel", S_PAUSE, 15'(0));
    ticks(3);
    send_key(1'b1, 1'b0, 8'h0C);
    expect_at(2, "f4_b_lat", S_PAUSE, 15'(0));
    expect_at(3, "f4_b_unpaused", S_PAUSE, 15'(1));
    ticks(3);
    send_key(1'b0, 1'b0, 8'h0C);
    ticks(3);

    // pause_clr beats a simultaneous edge
    joy_0[9] = 1'b1;
    pause_clr = 1'b1;
    for (int k = 1; k <= 3; k++) expect_at(k, "clr_wins", S_PAUSE, 15'(1));
    tick();
    pause_clr = 1'b0;
    ticks(2);
    joy_0[9] = 1'b0;
    tick();
    joy_0[9] = 1'b1;
    expect_at(1, "joy_pause_lat", S_PAUSE, 15'(1));
    expect_at(2, "joy_pause", S_PAUSE, 15'(0));
    tick();
    joy_0[9] = 1'b0;
    ticks(2);
    pause_clr = 1'b1;
    expect_at(2, "pause_clr", S_PAUSE, 15'(1));
    tick();
    pause_clr = 1'b0;
    ticks(2);
    joy_0[9] = 1'b1;
    expect_at(2, "repause", S_PAUSE, 15'(0));
    tick();
    joy_0[9] = 1'b0;
    ticks(2);

    // flush mid-pulse with key and joystick held
    send_key(1'b1, 1'b1, 8'h74);
    expect_at(2, "kbd_right", S_J1, 15'(5'b11110));
    ticks(3);
    joy_0[3] = 1'b1;
    joy_0[8] = 1'b1;
    expect_at(1, "up_plus_right", S_J1, 15'(5'b10110));
    expect_at(2, "pre_flush_coin", S_COIN, 15'(0));
    expect_at(3, "pre_flush_coin_b", S_COIN, 15'(0));
    expect_at(3, "pre_flush_coin8", S_COIN8, 15'(0));
    ticks(3);
    flush = 1'b1;
    for (int k = 1; k <= 3; k++)
      expect_at(k, "flush_outputs", S_ALL, {5'h1F, 5'h1F, 2'b11, 1'b1, 1'b0, 1'b1});
    ticks(3);
    flush = 1'b0;
    expect_at(1, "post_flush_j1", S_J1, 15'(5'b10111));
    expect_at(1, "post_flush_coin_lat", S_COIN, 15'(1));
    expect_at(2, "post_flush_coin", S_COIN, 15'(0));
    expect_at(2, "post_flush_coin8", S_COIN8, 15'(0));
    expect_at(3, "post_flush_coin_b", S_COIN, 15'(0));
    ticks(3);

    // asynchronous reset in the middle of a coin pulse
    #2;
    rst = 1'b1;
    #1;
    compare("async_rst_mid_pulse", S_ALL, IDLE_ALL);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: %0d entries pending, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
